grid_line_clear: RTL

Sequencer that owns the playfield grid's cell read/write port after a piece locks. It scans rows bottom-up and detects full rows, meaning every cell is non-zero. It removes each full row by shifting every row above it down by one and zero-filling row 0. It reports the number of rows cleared per pass and, optionally, a running score. It sits between the game-control FSM (start/done) and the grid storage (cell port); spawn and piece logic must not write the grid while `busy` is high.

---
 rtl/grid_line_clear_if.sv | 38 +++
 rtl/grid_line_clear.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/grid_line_clear_if.sv
// Bus between the line-clear sequencer, the game-control FSM (start/done/
// results) and the grid storage cell port (read/write).
interface grid_line_clear_if #(
  parameter int ROWS = 10,
  parameter int COLS = 10,
  parameter int CW   = 3
);
  localparam int RW  = $clog2(ROWS);
  localparam int CIW = $clog2(COLS);
  localparam int LW  = $clog2(ROWS + 1);

  logic           start;
  logic           busy;
  logic           done;
  logic [LW-1:0]  lines_cleared;
  logic [15:0]    score;
  logic [RW-1:0]  rd_row;
  logic [CIW-1:0] rd_col;
  logic [CW-1:0]  rd_data;
  logic           wr_en;
  logic [RW-1:0]  wr_row;
  logic [CIW-1:0] wr_col;
  logic [CW-1:0]  wr_data;

  // Sequencer side: owns the cell port and reports results.
  modport master (
    input  start, rd_data,
    output busy, done, lines_cleared, score,
    output rd_row, rd_col, wr_en, wr_row, wr_col, wr_data
  );

  // Environment side: game control plus grid storage.
  modport slave (
    output start, rd_data,
    input  busy, done, lines_cleared, score,
    input  rd_row, rd_col, wr_en, wr_row, wr_col, wr_data
  );
endinterface

// File: rtl/grid_line_clear.sv
// Line-clear sequencer: scans rows bottom-up, removes full rows by shifting
// everything above down one row, zero-fills row 0 and counts cleared rows.
// Optional running score enabled by defining GRID_LINE_CLEAR_SCORE_EN.
module grid_line_clear #(
  parameter int ROWS = 10,
  parameter int COLS = 10,
  parameter int CW   = 3
) (
  input  logic            clk,
  input  logic            rst,
  grid_line_clear_if.master bus
);
  localparam int RW  = $clog2(ROWS);
  localparam int CIW = $clog2(COLS);
  localparam int LW  = $clog2(ROWS + 1);
  localparam int NW  = $clog2(COLS + 1);

  localparam logic [NW-1:0] N_COLS = NW'(COLS);
  localparam logic [NW-1:0] N_LAST = NW'(COLS - 1);
  localparam logic [RW-1:0] R_TOP  = RW'(ROWS - 1);
  localparam logic [RW-1:0] R_ONE  = RW'(1);
  localparam logic [RW-1:0] R_TWO  = RW'(2);

  typedef enum logic [2:0] {IDLE, CHECK, COPY, CLEAR, DONE} state_t;

  state_t         state_q;
  logic [RW-1:0]  r_q;        // row under test
  logic [RW-1:0]  rr_q;       // destination row of the current copy
  logic [NW-1:0]  cnt_q;      // column / phase counter within a state
  logic           acc_q;      // running AND of non-zero cells in the row
  logic [LW-1:0]  lines_q;
  logic           busy_q, done_q;
  logic           wr_en_q, wr_copy_q;
  logic [RW-1:0]  wr_row_q, rd_row_q;
  logic [CIW-1:0] wr_col_q, rd_col_q;

  logic cell_nz;
  assign cell_nz = |bus.rd_data;

  // Sequencer FSM; all outputs except the copy data path are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      r_q       <= '0;
      rr_q      <= '0;
      cnt_q     <= '0;
      acc_q     <= 1'b1;
      lines_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_copy_q <= 1'b0;
      wr_row_q  <= '0;
      wr_col_q  <= '0;
      rd_row_q  <= '0;
      rd_col_q  <= '0;
    end else begin
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_copy_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q  <= CHECK;
            busy_q   <= 1'b1;
            r_q      <= R_TOP;
            lines_q  <= '0;
            cnt_q    <= '0;
            acc_q    <= 1'b1;
            rd_row_q <= R_TOP;
            rd_col_q <= '0;
          end
        end
        CHECK: begin
          // Data lags the address by one cycle, so cnt=k sees column k-1.
          if (cnt_q != '0) acc_q <= acc_q & cell_nz;
          if (cnt_q != N_COLS) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q != N_LAST) rd_col_q <= CIW'(cnt_q + 1'b1);
          end else begin
            cnt_q <= '0;
            acc_q <= 1'b1;
            if (acc_q && cell_nz) begin
              if (r_q == '0) begin
                // Nothing above row 0 to shift; just wipe it.
                state_q  <= CLEAR;
                wr_en_q  <= 1'b1;
                wr_row_q <= '0;
                wr_col_q <= '0;
              end else begin
                state_q  <= COPY;
                rr_q     <= r_q;
                rd_row_q <= r_q - 1'b1;
                rd_col_q <= '0;
              end
            end else if (r_q == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              r_q      <= r_q - 1'b1;
              rd_row_q <= r_q - 1'b1;
              rd_col_q <= '0;
            end
          end
        end
        COPY: begin
          // Read (rr-1,c) while writing (rr,c-1) with the data just returned.
          if (cnt_q != N_COLS) begin
            wr_en_q   <= 1'b1;
            wr_copy_q <= 1'b1;
            wr_row_q  <= rr_q;
            wr_col_q  <= CIW'(cnt_q);
            cnt_q     <= cnt_q + 1'b1;
            if (cnt_q != N_LAST) rd_col_q <= CIW'(cnt_q + 1'b1);
          end else begin
            cnt_q <= '0;
            rr_q  <= rr_q - 1'b1;
            if (rr_q == R_ONE) begin
              state_q  <= CLEAR;
              wr_en_q  <= 1'b1;
              wr_row_q <= '0;
              wr_col_q <= '0;
            end else begin
              rd_row_q <= rr_q - R_TWO;
              rd_col_q <= '0;
            end
          end
        end
        CLEAR: begin
          if (cnt_q != N_LAST) begin
            wr_en_q  <= 1'b1;
            wr_col_q <= CIW'(cnt_q + 1'b1);
            cnt_q    <= cnt_q + 1'b1;
          end else begin
            // Re-test the same row: it now holds what used to sit above it.
            cnt_q    <= '0;
            lines_q  <= lines_q + 1'b1;
            state_q  <= CHECK;
            acc_q    <= 1'b1;
            rd_row_q <= r_q;
            rd_col_q <= '0;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.lines_cleared = lines_q;
  assign bus.rd_row        = rd_row_q;
  assign bus.rd_col        = rd_col_q;
  assign bus.wr_en         = wr_en_q;
  assign bus.wr_row        = wr_row_q;
  assign bus.wr_col        = wr_col_q;
  // Copy writes forward the registered read data straight through; clears write 0.
  assign bus.wr_data       = wr_copy_q ? bus.rd_data : '0;

`ifdef GRID_LINE_CLEAR_SCORE_EN
  logic [15:0] score_q;
  logic [16:0] score_sum;

  function automatic logic [16:0] pts(input logic [LW-1:0] n);
    if (int'(n) == 0)      pts = 17'd0;
    else if (int'(n) == 1) pts = 17'd40;
    else if (int'(n) == 2) pts = 17'd100;
    else if (int'(n) == 3) pts = 17'd300;
    else                   pts = 17'd1200;
  endfunction

  assign score_sum = {1'b0, score_q} + pts(lines_q);

  // Saturating score accumulation on the DONE cycle.
  always_ff @(posedge clk) begin
    if (rst)                  score_q <= '0;
    else if (state_q == DONE) score_q <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end

  assign bus.score = score_q;
`else
  assign bus.score = '0;
`endif
endmodule
